rf_writeback_ctrl: RTL

Write-back controller for the 32x32 integer register file: accepts results from the ALU and the load/store unit over valid/ready handshakes, buffers them in a small FIFO, and drives the register file's single write port (`data`, `wd_en`, `wd_sel`) with at most one write per cycle. It also keeps a per-register pending scoreboard so decode can stall on operands whose producer has issued but not yet written back. Writes to x0 are discarded here, so the register file never sees them.

---
 rtl/rf_writeback_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl
//   Write-back controller for the 32x32 integer register file. ALU and LSU
//   results arrive over valid/ready handshakes. At most one result is
//   accepted per cycle, under round-robin arbitration. Accepted results
//   are buffered in a small FIFO. The FIFO head drives the single register
//   file write port, one write per cycle. A per-register pending scoreboard
//   lets decode stall on operands still in flight. Results for x0 are
//   acknowledged but never buffered or written.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data   load result handshake
//   issue_valid, issue_rd           decode issued a writer of issue_rd
//   rs1_add/rs1_busy, rs2_add/rs2_busy    operand pending queries
//   wd_en, wd_sel, data             register file write port (registered)
//   fifo_count                      entries currently buffered
module rf_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [4:0]    lsu_rd,
  input  logic [31:0]   lsu_data,
  input  logic          issue_valid,
  input  logic [4:0]    issue_rd,
  input  logic [4:0]    rs1_add,
  input  logic [4:0]    rs2_add,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          wd_en,
  output logic [4:0]    wd_sel,
  output logic [31:0]   data,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e          rr, rr_nxt;
  logic [4:0]    rd_mem  [DEPTH];
  logic [31:0]   dat_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   busy, busy_nxt;

  logic          full, empty;
  logic          push, pop;
  logic [4:0]    push_rd;
  logic [31:0]   push_data;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign fifo_count = count;

  // Handshake and arbitration. A full FIFO refuses both producers, even
  // when it pops in the same cycle.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    rr_nxt    = rr;
    if (!full) begin
      if (alu_valid && lsu_valid) begin
        if (rr == SRC_ALU) begin
          alu_ready = 1'b1;
          rr_nxt    = SRC_LSU;
        end else begin
          lsu_ready = 1'b1;
          rr_nxt    = SRC_ALU;
        end
      end else begin
        alu_ready = alu_valid;
        lsu_ready = lsu_valid;
      end
    end
  end

  // x0 results complete the handshake but are dropped here.
  always_comb begin
    push_rd   = lsu_rd;
    push_data = lsu_data;
    if (alu_ready) begin
      push_rd   = alu_rd;
      push_data = alu_data;
    end
  end

  assign push = (alu_ready || lsu_ready) && (push_rd != 5'd0);
  assign pop  = !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]  <= push_rd;
      dat_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr     <= SRC_LSU;
      wd_en  <= 1'b0;
      wd_sel <= '0;
      data   <= '0;
    end else begin
      rr <= rr_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      wd_en <= pop;
      if (pop) begin
        wd_sel <= rd_mem[rd_ptr];
        data   <= dat_mem[rd_ptr];
      end
    end
  end

  // Clear on write-back first, then set on issue, so a same-cycle issue of
  // the register being written leaves it pending.
  always_comb begin
    busy_nxt = busy;
    if (wd_en) busy_nxt[wd_sel] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1_add];
  assign rs2_busy = busy[rs2_add];

endmodule
